// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory bus between instruction fetch and data access.
// Data wins contention, but instruction fetch waits at most DATA_BURST data transactions.
module mem_arbiter #(
    parameter int unsigned DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] instr_m_addr,
    input  logic        instr_m_access,
    output logic        instr_m_ack,
    output logic [15:0] instr_m_data_in,
    input  logic [18:0] data_m_addr,
    input  logic [15:0] data_m_data_out,
    input  logic        data_m_access,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    output logic        data_m_ack,
    output logic [15:0] data_m_data_in,
    output logic [18:0] q_m_addr,
    output logic [15:0] q_m_data_out,
    input  logic [15:0] q_m_data_in,
    output logic        q_m_access,
    output logic        q_m_wr_en,
    output logic [1:0]  q_m_bytesel,
    input  logic        q_m_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_e;

    localparam logic [3:0] BURST_MAX = 4'(DATA_BURST);

    state_e     state_q, state_d;
    logic [3:0] burst_q, burst_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (!instr_m_access) begin
                    burst_d = '0;
                end
                if (data_m_access && (!instr_m_access || burst_q < BURST_MAX)) begin
                    state_d = GRANT_D;
                    // Count data grants that made a waiting fetch wait longer.
                    if (instr_m_access) begin
                        burst_d = burst_q + 4'd1;
                    end
                end else if (instr_m_access) begin
                    state_d = GRANT_I;
                    burst_d = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (q_m_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        q_m_access   = 1'b0;
        q_m_addr     = '0;
        q_m_data_out = '0;
        q_m_wr_en    = 1'b0;
        q_m_bytesel  = 2'b00;
        instr_m_ack  = 1'b0;
        data_m_ack   = 1'b0;
        case (state_q)
            GRANT_I: begin
                q_m_access  = 1'b1;
                q_m_addr    = instr_m_addr;
                q_m_bytesel = 2'b11;
                instr_m_ack = q_m_ack;
            end
            GRANT_D: begin
                q_m_access   = 1'b1;
                q_m_addr     = data_m_addr;
                q_m_data_out = data_m_data_out;
                q_m_wr_en    = data_m_wr_en;
                q_m_bytesel  = data_m_bytesel;
                data_m_ack   = q_m_ack;
            end
            default: ;
        endcase
    end

    // Each port qualifies the shared read data with its own ack.
    assign instr_m_data_in = q_m_data_in;
    assign data_m_data_in  = q_m_data_in;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares a single external memory bus between the core's instruction (prefetch) port and data (load/store) port. The two ports use the same access/ack protocol.
- Sits between Core and the memory/bus interface.
- Data has priority, with a bounded-starvation guarantee for instruction fetch.
- One grant is held per transaction until the slave acks.

Parameters:
DATA_BURST, 4, max consecutive data grants issued while an instruction request is pending; range 1..15.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous reset, active-low.
instr_m_addr  in  19  instruction word address [19:1].
instr_m_access  in  1  instruction request, held until instr_m_ack.
instr_m_ack  out  1  instruction transaction complete.
instr_m_data_in  out  16  read data to prefetch.
data_m_addr  in  19  data word address [19:1].
data_m_data_out  in  16  write data from core.
data_m_access  in  1  data request, held until data_m_ack.
data_m_wr_en  in  1  1 = write.
data_m_bytesel  in  2  byte lanes.
data_m_ack  out  1  data transaction complete.
data_m_data_in  out  16  read data to load/store.
q_m_addr  out  19  shared bus address.
q_m_data_out  out  16  shared bus write data.
q_m_data_in  in  16  shared bus read data.
q_m_access  out  1  shared bus request.
q_m_wr_en  out  1  shared bus write enable.
q_m_bytesel  out  2  shared bus byte lanes.
q_m_ack  in  1  shared bus ack.

Behaviour:
- Reset and outputs:
  - Asynchronous: reset=0 forces state IDLE and burst counter 0 immediately.
  - All outputs are combinational from state and inputs, so q_m_access, acks, addr, data_out, wr_en and bytesel are all 0 while reset=0.
  - Reset mid-transaction abandons the transaction; no ack is issued.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - q_m_access=0; all q_m_* outputs are 0.
  - On a rising edge with requests pending:
    - data only -> GRANT_D.
    - instr only -> GRANT_I.
    - both pending and burst_cnt < DATA_BURST -> GRANT_D.
    - both pending and burst_cnt == DATA_BURST -> GRANT_I.
- GRANT_I:
  - q_m_access=1, q_m_addr=instr_m_addr, q_m_wr_en=0, q_m_bytesel=2'b11, q_m_data_out=0.
  - instr_m_ack=q_m_ack; data_m_ack=0.
- GRANT_D:
  - q_m_access=1; addr, data_out, wr_en and bytesel pass through from the data port.
  - data_m_ack=q_m_ack; instr_m_ack=0.
- Return to IDLE: on the edge where q_m_ack=1 in a GRANT state. There is always at least one IDLE cycle between transactions, so q_m_access drops for at least one cycle.
- Latency: a request seen in IDLE reaches the bus on the next cycle. Minimum transaction time is 2 cycles (IDLE plus a GRANT cycle with immediate ack).
- Read data: q_m_data_in is routed to both instr_m_data_in and data_m_data_in unconditionally. A port treats the data as valid only when its own ack is high.
- Grant holding: a grant is held until q_m_ack regardless of the requester's access level. The ack is still forwarded to that port. Dropping access before ack is a requester protocol violation; the arbiter does not abort.
- burst_cnt (4 bits):
  - Increments on entering GRANT_D while instr_m_access=1, saturating at DATA_BURST.
  - Cleared to 0 on entering GRANT_I.
  - Cleared to 0 in IDLE when instr_m_access=0.
- A q_m_ack arriving in IDLE is ignored; no port ack is asserted.
- Worst-case instruction wait: DATA_BURST data transactions.

Test Plan:
- Reset: hold reset=0 with both accesses high and q_m_ack=1 -> all outputs 0. Release; the next edge enters GRANT_D, and q_m_access=1 one cycle later.
- Instr only: instr_m_addr=19'h0F000, slave acks after 2 cycles -> q_m_addr=19'h0F000, q_m_bytesel=2'b11, q_m_wr_en=0. instr_m_ack is high one cycle with instr_m_data_in=q_m_data_in (16'hBEEF). data_m_ack stays 0.
- Data write: addr=19'h00100, data_out=16'h1234, bytesel=2'b01, wr_en=1 -> identical values on q_m_*. data_m_ack mirrors q_m_ack. Back in IDLE, q_m_access=0 for one cycle.
- Contention, DATA_BURST=4: both ports request continuously with immediate acks -> grant order D,D,D,D,I,D,D,D,D,I. Each grant is separated by one IDLE cycle.
- Simultaneous with no history: both requests rise together from IDLE with burst_cnt=0 -> GRANT_D first, then GRANT_I once data drops its access.
- Reset mid-transaction: assert reset=0 during GRANT_D before ack -> q_m_access falls to 0 asynchronously. No data_m_ack is issued. After release, a pending instr request is granted.
